muldiv_unit: RTL and testbench

//   Iterative RV32M multiply/divide unit; companion to the single-cycle ALU in the EX stage.

---
 rtl/muldiv_unit_pkg.sv | 19 +
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_unit.sv | 109 ++++++++++
 tb/tb_muldiv_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: RV32M funct3 encodings and FSM states shared by the multiply/divide unit
package muldiv_unit_pkg;

    localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_OP_MUL    = 3'b000;
    localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_OP_MULH   = 3'b001;
    localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_OP_MULHSU = 3'b010;
    localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_OP_MULHU  = 3'b011;
    localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_OP_DIV    = 3'b100;
    localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_OP_DIVU   = 3'b101;
    localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_OP_REM    = 3'b110;
    localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: STEP bits of unsigned shift-add multiply or restoring divide on a {hi, lo} accumulator
module muldiv_step #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc_nx
);

    logic [2*XLEN-1:0] a;
    logic [XLEN:0]     sh;
    logic [XLEN:0]     diff;
    logic [XLEN:0]     sum;

    // divide: shift remainder:quotient left, keep the trial subtraction if it does not borrow;
    // multiply: add b to the high half when the multiplier lsb is set, then shift right
    always_comb begin
        a    = acc;
        sh   = '0;
        diff = '0;
        sum  = '0;
        for (int i = 0; i < STEP; i++) begin
            sh   = {a[2*XLEN-1:XLEN], a[XLEN-1]};
            diff = sh - {1'b0, b};
            sum  = {1'b0, a[2*XLEN-1:XLEN]} + (a[0] ? {1'b0, b} : '0);
            a    = is_div ? (diff[XLEN] ? {sh[XLEN-1:0], a[XLEN-2:0], 1'b0}
                                        : {diff[XLEN-1:0], a[XLEN-2:0], 1'b1})
                          : {sum, a[XLEN-1:1]};
        end
        acc_nx = a;
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with valid/ready handshake, flush and sign fix-up
import muldiv_unit_pkg::*;

module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    localparam int ITER = XLEN / STEP;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic              neg;
    logic [XLEN-1:0]   b;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nx;
    logic              sa, sb, na, nb, div_zero, ovf;
    logic [XLEN-1:0]   ma, mb, sp_res, div_raw, fin;
    logic [2*XLEN-1:0] prod;

    muldiv_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
        .is_div (op[2]),
        .acc    (acc),
        .b      (b),
        .acc_nx (acc_nx)
    );

    assign in_ready = (state == IDLE);

    // operand magnitudes, fast-path divide results and final sign fix-up of the last iteration
    always_comb begin
        sa = in_op inside {kSAIL_MICROARCHITECTURE_MULDIV_OP_MULH, kSAIL_MICROARCHITECTURE_MULDIV_OP_MULHSU,
                           kSAIL_MICROARCHITECTURE_MULDIV_OP_DIV, kSAIL_MICROARCHITECTURE_MULDIV_OP_REM};
        sb = in_op inside {kSAIL_MICROARCHITECTURE_MULDIV_OP_MULH, kSAIL_MICROARCHITECTURE_MULDIV_OP_DIV,
                           kSAIL_MICROARCHITECTURE_MULDIV_OP_REM};
        na = sa & in_a[XLEN-1];
        nb = sb & in_b[XLEN-1];
        ma = na ? -in_a : in_a;
        mb = nb ? -in_b : in_b;
        div_zero = in_op[2] && (in_b == '0);
        ovf = (in_op == kSAIL_MICROARCHITECTURE_MULDIV_OP_DIV || in_op == kSAIL_MICROARCHITECTURE_MULDIV_OP_REM)
              && (in_a == MIN_NEG) && (in_b == '1);
        sp_res = div_zero ? (in_op[1] ? in_a : '1) : (in_op[1] ? '0 : in_a);
        prod = neg ? -acc_nx : acc_nx;
        div_raw = op[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
        fin = op[2] ? (neg ? -div_raw : div_raw)
                    : (op == kSAIL_MICROARCHITECTURE_MULDIV_OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end

    // FSM: accept, iterate, fix up on entry to DONE; out_valid follows DONE by one edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op         <= '0;
            neg        <= 1'b0;
            b          <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op    <= in_op;
                    neg   <= (in_op[2] & in_op[1]) ? na : (na ^ nb);
                    b     <= mb;
                    acc   <= {{XLEN{1'b0}}, ma};
                    cnt   <= '0;
                    state <= (div_zero || ovf) ? DONE : BUSY;
                    if (div_zero || ovf) out_result <= sp_res;
                end
                BUSY: begin
                    acc <= acc_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) begin
                        state      <= DONE;
                        out_result <= fin;
                    end
                end
                DONE: if (out_valid && out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven checks of muldiv_unit at STEP 1/2/4 plus handshake, flush and reset sequences
import muldiv_unit_pkg::*;

module tb_muldiv_unit;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          sp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  iv = '0;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [31:0] res [3];

    vec_t tv[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        muldiv_unit #(.XLEN(32), .STEP(1 << g)) dut (
            .clk        (clk),
            .reset      (rst),
            .flush      (flush),
            .in_valid   (iv[g]),
            .in_ready   (ir[g]),
            .in_op      (op),
            .in_a       (a),
            .in_b       (b),
            .out_valid  (ov[g]),
            .out_ready  (out_ready),
            .out_result (res[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_v(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e, input bit s);
        tv.push_back('{o, x, y, e, s});
    endtask

    task automatic run_op(input int d, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; iv[d] = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        iv[d] = 1'b0; op = ~o; a = ~x; b = ~y;
        lat = 0;
        while (!ov[d] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = res[d];
    endtask

    task automatic release_out(input int d, input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, " out_valid drop"}, 32'(ov[d]), 32'd0);
        chk({name, " in_ready back"}, 32'(ir[d]), 32'd1);
        out_ready = 1'b0;
    endtask

    task automatic quiet(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
            seen |= ov[0];
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int lat, nres, nacc;
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_MUL,    32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_MULHSU, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 0);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_MUL,    32'h3,        32'h4,        32'hC,        0);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_MULH,   32'h12345678, 32'h10,       32'h1,        0);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 0);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 0);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_DIVU,   32'd100,      32'd7,        32'd14,       0);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_REMU,   32'd100,      32'd7,        32'd2,        0);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_DIV,    32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_REM,    32'h7,        32'hFFFFFFFE, 32'h1,        0);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_DIVU,   32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 0);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h0,        0);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_DIVU,   32'h5,        32'h0,        32'hFFFFFFFF, 1);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_REM,    32'h5,        32'h0,        32'h5,        1);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        1);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_REMU,   32'h5,        32'h0,        32'h5,        1);
        add_v(kSAIL_MICROARCHITECTURE_MULDIV_OP_DIV,    32'h5,        32'h0,        32'hFFFFFFFF, 1);

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset in_ready s%0d", 1 << d), 32'(ir[d]), 32'd1);
            chk($sformatf("reset out_valid s%0d", 1 << d), 32'(ov[d]), 32'd0);
            chk($sformatf("reset out_result s%0d", 1 << d), res[d], 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int d = 0; d < 3; d++) begin
            foreach (tv[i]) begin
                run_op(d, tv[i].op, tv[i].a, tv[i].b, r, lat);
                chk($sformatf("s%0d v%0d result", 1 << d, i), r, tv[i].exp);
                chk($sformatf("s%0d v%0d latency", 1 << d, i), 32'(lat), tv[i].sp ? 32'd1 : 32'(32 / (1 << d) + 1));
                release_out(d, $sformatf("s%0d v%0d", 1 << d, i));
            end
        end

        run_op(0, kSAIL_MICROARCHITECTURE_MULDIV_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
        chk("bp first result", r, 32'hFFFFFFFE);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d result", k), res[0], 32'hFFFFFFFE);
            chk($sformatf("bp hold%0d out_valid", k), 32'(ov[0]), 32'd1);
            chk($sformatf("bp hold%0d in_ready", k), 32'(ir[0]), 32'd0);
        end
        release_out(0, "bp");

        @(negedge clk);
        op = kSAIL_MICROARCHITECTURE_MULDIV_OP_DIVU; a = 32'h5; b = 32'h0;
        iv[0] = 1'b1; out_ready = 1'b1;
        nres = 0; nacc = 0;
        for (int k = 0; k < 30; k++) begin
            if (ov[0]) begin
                nres++;
                chk($sformatf("b2b result%0d", nres), res[0], 32'hFFFFFFFF);
            end
            if (ir[0]) nacc++;
            if (ov[0] && ir[0]) chk("b2b overlap", 32'd1, 32'(ir[0] & ~ov[0]));
            @(negedge clk);
        end
        iv[0] = 1'b0; out_ready = 1'b0;
        chk("b2b results", 32'(nres), 32'd10);
        chk("b2b accepts", 32'(nacc), 32'd10);

        @(negedge clk);
        op = kSAIL_MICROARCHITECTURE_MULDIV_OP_MUL; a = 32'h3; b = 32'h4; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy in_ready", 32'(ir[0]), 32'd1);
        chk("flush busy out_valid", 32'(ov[0]), 32'd0);
        quiet("flush busy no result", 40);

        @(negedge clk);
        iv[0] = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0; flush = 1'b0;
        chk("flush idle no accept", 32'(ir[0]), 32'd1);
        quiet("flush idle no result", 40);

        run_op(0, kSAIL_MICROARCHITECTURE_MULDIV_OP_DIVU, 32'd100, 32'd7, r, lat);
        chk("flush hs result", r, 32'd14);
        @(negedge clk);
        out_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; flush = 1'b0;
        chk("flush hs out_valid", 32'(ov[0]), 32'd0);
        chk("flush hs in_ready", 32'(ir[0]), 32'd1);
        quiet("flush hs no duplicate", 10);

        @(negedge clk);
        op = kSAIL_MICROARCHITECTURE_MULDIV_OP_MUL; a = 32'h7; b = 32'h9; iv = 3'b111;
        @(posedge clk); #1;
        iv = 3'b000;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("mid reset in_ready s%0d", 1 << d), 32'(ir[d]), 32'd1);
            chk($sformatf("mid reset out_valid s%0d", 1 << d), 32'(ov[d]), 32'd0);
            chk($sformatf("mid reset out_result s%0d", 1 << d), res[d], 32'd0);
        end
        #3 rst = 1'b0;
        quiet("mid reset no pulse", 40);
        run_op(0, kSAIL_MICROARCHITECTURE_MULDIV_OP_MUL, 32'h3, 32'h4, r, lat);
        chk("post reset mul", r, 32'hC);
        chk("post reset latency", 32'(lat), 32'd33);
        release_out(0, "post reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
